// File: rtl/hotspot_iter_sched.sv
// Iteration scheduler for the thermal stencil core: pairs temp/power streams into core issues,
// bounds in-flight cells, tags pass ends. Optional perf counters via HOTSPOT_SCHED_PERF_EN.
module hotspot_iter_sched #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CELL_W       = 20,
  parameter int unsigned ITER_W       = 16,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                  aclk,
  input  logic                  axi_resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CELL_W-1:0]     num_cells,
  input  logic [ITER_W-1:0]     num_iters,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_lock,
  output logic [ITER_W-1:0]     iter_count,
  input  logic [DATA_WIDTH-1:0] s_axis_temp_data,
  input  logic                  s_axis_temp_valid,
  output logic                  s_axis_temp_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_power_data,
  input  logic                  s_axis_power_valid,
  output logic                  s_axis_power_ready,
  output logic [DATA_WIDTH-1:0] m_core_temp_data,
  output logic [DATA_WIDTH-1:0] m_core_power_data,
  output logic                  m_core_valid,
  input  logic                  m_core_ready,
  input  logic [DATA_WIDTH-1:0] s_core_result_data,
  input  logic                  s_core_result_valid,
  output logic                  s_core_result_ready,
  output logic [DATA_WIDTH-1:0] m_axis_result_data,
  output logic                  m_axis_result_valid,
  input  logic                  m_axis_result_ready,
  output logic                  m_axis_result_tlast
`ifdef HOTSPOT_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned InflW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [InflW-1:0] MaxInfl = InflW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CELL_W-1:0] r_cells, r_issue_cnt, r_res_cnt;
  logic [ITER_W-1:0] r_iters, r_iter_count;
  logic [InflW-1:0]  r_inflight;

  logic w_cfg_zero, w_can_issue, w_active, w_issue, w_accept, w_dec;
  logic w_start_acc, w_abort_run, w_pass_done, w_last_pass;

  assign w_start_acc = (r_state == StIdle) && start && !abort;
  assign w_abort_run = (r_state != StIdle) && abort;
  // A zero-length run spends one cycle in RUN with all handshakes closed, then ends.
  assign w_cfg_zero  = (r_cells == '0) || (r_iters == '0);
  assign w_can_issue = (r_state == StRun) && !w_cfg_zero && (r_issue_cnt < r_cells) &&
                       (r_inflight < MaxInfl);
  assign w_active    = ((r_state == StRun) && !w_cfg_zero) || (r_state == StDrain);

  assign m_core_temp_data   = s_axis_temp_data;
  assign m_core_power_data  = s_axis_power_data;
  assign m_core_valid       = s_axis_temp_valid && s_axis_power_valid && w_can_issue;
  assign s_axis_temp_ready  = m_core_ready && s_axis_power_valid && w_can_issue;
  assign s_axis_power_ready = m_core_ready && s_axis_temp_valid && w_can_issue;
  assign w_issue            = m_core_valid && m_core_ready;

  assign m_axis_result_data  = s_core_result_data;
  assign m_axis_result_valid = w_active && s_core_result_valid;
  assign s_core_result_ready = w_active && m_axis_result_ready;
  assign m_axis_result_tlast = m_axis_result_valid && (r_res_cnt == r_cells - CELL_W'(1));
  assign w_accept            = m_axis_result_valid && m_axis_result_ready;
  assign w_dec               = w_accept && (r_inflight != '0);

  assign w_pass_done = (r_state == StDrain) && (r_res_cnt == r_cells);
  assign w_last_pass = (r_iter_count + ITER_W'(1)) == r_iters;

  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StDone);
  assign cfg_lock   = busy;
  assign iter_count = r_iter_count;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start_acc) w_state_d = StRun;
      StRun: begin
        if (w_cfg_zero) w_state_d = StDone;
        else if (r_issue_cnt == r_cells) w_state_d = StDrain;
      end
      StDrain: if (w_pass_done) w_state_d = w_last_pass ? StDone : StRun;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_abort_run) w_state_d = StIdle;
  end

  always_ff @(posedge aclk) begin
    if (!axi_resetn) begin
      r_state      <= StIdle;
      r_cells      <= '0;
      r_iters      <= '0;
      r_issue_cnt  <= '0;
      r_res_cnt    <= '0;
      r_iter_count <= '0;
      r_inflight   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start_acc) begin
        r_cells      <= num_cells;
        r_iters      <= num_iters;
        r_issue_cnt  <= '0;
        r_res_cnt    <= '0;
        r_iter_count <= '0;
        r_inflight   <= '0;
      end else if (w_abort_run) begin
        r_issue_cnt  <= '0;
        r_res_cnt    <= '0;
        r_iter_count <= '0;
        r_inflight   <= '0;
      end else begin
        if (w_pass_done) begin
          r_iter_count <= r_iter_count + ITER_W'(1);
          r_issue_cnt  <= '0;
          r_res_cnt    <= '0;
        end else begin
          if (w_issue)  r_issue_cnt <= r_issue_cnt + CELL_W'(1);
          if (w_accept) r_res_cnt   <= r_res_cnt + CELL_W'(1);
        end
        if (w_issue && !w_dec)      r_inflight <= r_inflight + InflW'(1);
        else if (!w_issue && w_dec) r_inflight <= r_inflight - InflW'(1);
      end
    end
  end

`ifdef HOTSPOT_SCHED_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == StRun) && s_axis_temp_valid && s_axis_power_valid && !w_issue;

  always_ff @(posedge aclk) begin
    if (!axi_resetn) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_start_acc) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy && (r_perf_cycles != '1))   r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_stall && (r_perf_stall != '1)) r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_hotspot_iter_sched.sv
// Self-checking bench for hotspot_iter_sched: random stream/core/sink traffic against a
// phase-level reference model with a queue standing in for the core pipeline.
module tb_hotspot_iter_sched;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic        aclk = 1'b0;
  logic        axi_resetn, start, abort;
  logic [19:0] num_cells;
  logic [15:0] num_iters;
  logic        busy, done, cfg_lock;
  logic [15:0] iter_count;
  logic [31:0] s_axis_temp_data, s_axis_power_data, m_core_temp_data, m_core_power_data;
  logic        s_axis_temp_valid, s_axis_temp_ready, s_axis_power_valid, s_axis_power_ready;
  logic        m_core_valid, m_core_ready;
  logic [31:0] s_core_result_data, m_axis_result_data;
  logic        s_core_result_valid, s_core_result_ready;
  logic        m_axis_result_valid, m_axis_result_ready, m_axis_result_tlast;
`ifdef HOTSPOT_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  hotspot_iter_sched dut (
    .aclk(aclk), .axi_resetn(axi_resetn), .start(start), .abort(abort),
    .num_cells(num_cells), .num_iters(num_iters),
    .busy(busy), .done(done), .cfg_lock(cfg_lock), .iter_count(iter_count),
    .s_axis_temp_data(s_axis_temp_data), .s_axis_temp_valid(s_axis_temp_valid),
    .s_axis_temp_ready(s_axis_temp_ready),
    .s_axis_power_data(s_axis_power_data), .s_axis_power_valid(s_axis_power_valid),
    .s_axis_power_ready(s_axis_power_ready),
    .m_core_temp_data(m_core_temp_data), .m_core_power_data(m_core_power_data),
    .m_core_valid(m_core_valid), .m_core_ready(m_core_ready),
    .s_core_result_data(s_core_result_data), .s_core_result_valid(s_core_result_valid),
    .s_core_result_ready(s_core_result_ready),
    .m_axis_result_data(m_axis_result_data), .m_axis_result_valid(m_axis_result_valid),
    .m_axis_result_ready(m_axis_result_ready), .m_axis_result_tlast(m_axis_result_tlast)
`ifdef HOTSPOT_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0, n_fail = 0;
  // reference model: run phase, per-pass counts, and the core pipeline as a queue of cell ids
  int ph = P_IDLE, m_cells = 0, m_iters = 0, m_iter = 0, m_issued = 0, m_acc = 0;
  int unsigned core_q[$];
  int unsigned k_next = 0;
  bit known = 0;
  int p_tv, p_pv, p_cr, p_rv, p_mr;
  int cyc = 0, dut_issues, dut_accepts, dut_tlasts, dut_dones, tlast_cyc, done_cyc, max_infl;
  bit saw_ready;

  function automatic logic [31:0] tword(input int unsigned k);
    return 32'h1357_0000 ^ (k * 32'h9E37_79B9);
  endfunction
  function automatic logic [31:0] pword(input int unsigned k);
    return (k * 32'h85EB_CA6B) + 32'h7;
  endfunction
  function automatic logic [31:0] rword(input int unsigned k);
    logic [31:0] p;
    p = pword(k);
    return tword(k) ^ {p[15:0], p[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    dut_issues = 0; dut_accepts = 0; dut_tlasts = 0; dut_dones = 0;
    tlast_cyc = -100; done_cyc = -100; max_infl = 0; saw_ready = 0;
  endtask

  task automatic drive_random();
    s_axis_temp_valid   = ($urandom_range(99) < p_tv);
    s_axis_power_valid  = ($urandom_range(99) < p_pv);
    s_axis_temp_data    = tword(k_next);
    s_axis_power_data   = pword(k_next);
    m_core_ready        = ($urandom_range(99) < p_cr);
    m_axis_result_ready = ($urandom_range(99) < p_mr);
    if (core_q.size() > 0 && $urandom_range(99) < p_rv) begin
      s_core_result_valid = 1'b1;
      s_core_result_data  = rword(core_q[0]);
    end else begin
      s_core_result_valid = 1'b0;
      s_core_result_data  = $urandom;
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then drive next inputs.
  task automatic step();
    logic e_busy, e_can, e_issue, e_active, e_rv, e_acc;
    @(negedge aclk);
    cyc++;
    if (m_core_valid && m_core_ready) dut_issues++;
    if (m_axis_result_valid && m_axis_result_ready) begin
      dut_accepts++;
      if (m_axis_result_tlast) begin dut_tlasts++; tlast_cyc = cyc; end
    end
    if (done) begin dut_dones++; done_cyc = cyc; end
    if (s_axis_temp_ready || s_axis_power_ready || s_core_result_ready) saw_ready = 1;
    if (dut_issues - dut_accepts > max_infl) max_infl = dut_issues - dut_accepts;
    e_issue = 0; e_acc = 0;
    if (known) begin
      e_busy   = (ph != P_IDLE);
      e_can    = (ph == P_RUN) && m_cells != 0 && m_iters != 0 && m_issued < m_cells &&
                 core_q.size() < 16;
      e_issue  = s_axis_temp_valid && s_axis_power_valid && m_core_ready && e_can;
      e_active = ((ph == P_RUN) && m_cells != 0 && m_iters != 0) || (ph == P_DRAIN);
      e_rv     = e_active && s_core_result_valid;
      e_acc    = e_rv && m_axis_result_ready;
      chk("busy", busy, e_busy);
      chk("done", done, ph == P_DONE);
      chk("cfg_lock", cfg_lock, e_busy);
      chk("iter_count", iter_count, m_iter);
      chk("core_valid", m_core_valid, s_axis_temp_valid && s_axis_power_valid && e_can);
      chk("temp_ready", s_axis_temp_ready, m_core_ready && s_axis_power_valid && e_can);
      chk("power_ready", s_axis_power_ready, m_core_ready && s_axis_temp_valid && e_can);
      chk("res_valid", m_axis_result_valid, e_rv);
      chk("res_ready", s_core_result_ready, e_active && m_axis_result_ready);
      chk("tlast", m_axis_result_tlast, e_rv && (m_acc == m_cells - 1));
      if (e_issue) begin
        chk("core_temp_data", m_core_temp_data, tword(k_next));
        chk("core_power_data", m_core_power_data, pword(k_next));
      end
      if (e_rv) chk("res_data", m_axis_result_data, rword(core_q[0]));
    end
    if (!axi_resetn) begin
      ph = P_IDLE; m_iter = 0; m_issued = 0; m_acc = 0; core_q.delete(); known = 1;
    end else if (known) begin
      if (e_issue) begin core_q.push_back(k_next); k_next++; end
      if (e_acc) void'(core_q.pop_front());
      if (ph != P_IDLE && abort) begin
        ph = P_IDLE; m_iter = 0; m_issued = 0; m_acc = 0; core_q.delete();
      end else begin
        case (ph)
          P_IDLE: if (start && !abort) begin
            ph = P_RUN; m_cells = int'(num_cells); m_iters = int'(num_iters);
            m_iter = 0; m_issued = 0; m_acc = 0;
          end
          P_RUN: begin
            if (m_cells == 0 || m_iters == 0) ph = P_DONE;
            else if (m_issued == m_cells) ph = P_DRAIN;
            if (e_issue) m_issued++;
            if (e_acc) m_acc++;
          end
          P_DRAIN: begin
            if (m_acc == m_cells) begin
              m_iter++; m_issued = 0; m_acc = 0;
              ph = (m_iter == m_iters) ? P_DONE : P_RUN;
            end else if (e_acc) m_acc++;
          end
          default: ph = P_IDLE;
        endcase
      end
    end
    @(posedge aclk);
    #1;
    drive_random();
  endtask

  task automatic set_probs(input int tv, input int pv, input int cr, input int rv, input int mr);
    p_tv = tv; p_pv = pv; p_cr = cr; p_rv = rv; p_mr = mr;
  endtask

  task automatic launch(input int cells, input int iters);
    num_cells = 20'(cells);
    num_iters = 16'(iters);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while (ph != P_IDLE && n < budget) begin step(); n++; end
    chk({tag, "_finished"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    axi_resetn = 1'b0; start = 1'b0; abort = 1'b0; num_cells = '0; num_iters = '0;
    set_probs(100, 100, 100, 100, 100);
    drive_random();
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_iter", iter_count, 16'd0);
    chk("rst_core_valid", m_core_valid, 1'b0);
    chk("rst_temp_ready", s_axis_temp_ready, 1'b0);
    chk("rst_res_ready", s_core_result_ready, 1'b0);
    chk("rst_res_valid", m_axis_result_valid, 1'b0);
    axi_resetn = 1'b1;
    step();

    // 10 cells, one pass, everything always ready
    clr_stats();
    launch(10, 1);
    run_until_idle("a", 200);
    chk("a_issues", dut_issues, 10);
    chk("a_results", dut_accepts, 10);
    chk("a_tlasts", dut_tlasts, 1);
    chk("a_done_lat", done_cyc - tlast_cyc, 2);
    chk("a_dones", dut_dones, 1);

    // 4 cells x 3 passes with random traffic; a start during the run is ignored
    clr_stats();
    set_probs(70, 60, 80, 60, 70);
    launch(4, 3);
    repeat (5) step();
    num_cells = 20'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_idle("b", 500);
    chk("b_tlasts", dut_tlasts, 3);
    chk("b_iter", iter_count, 16'd3);
    chk("b_dones", dut_dones, 1);
    chk("b_results", dut_accepts, 12);

    // result sink stalled: issue stops at the in-flight cap
    clr_stats();
    set_probs(100, 100, 100, 100, 0);
    launch(40, 1);
    repeat (30) step();
    chk("c_capped_issues", dut_issues, 16);
    chk("c_core_valid_held", m_core_valid, 1'b0);
    chk("c_temp_ready_held", s_axis_temp_ready, 1'b0);
    set_probs(100, 100, 100, 70, 60);
    run_until_idle("c", 500);
    chk("c_issues", dut_issues, 40);
    chk("c_max_inflight_ok", max_infl <= 16, 1'b1);

    // lone temp stream is never consumed
    clr_stats();
    set_probs(100, 0, 100, 100, 100);
    launch(3, 1);
    repeat (6) step();
    chk("d_no_issue", dut_issues, 0);
    chk("d_temp_ready", s_axis_temp_ready, 1'b0);
    set_probs(100, 100, 100, 100, 100);
    run_until_idle("d", 100);
    chk("d_issues", dut_issues, 3);

    // zero passes: done two cycles after start, no handshake opened
    clr_stats();
    launch(5, 0);
    n = cyc;
    run_until_idle("e", 20);
    chk("e_done_lat", done_cyc - n, 2);
    chk("e_no_ready", saw_ready, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", busy, 1'b0);

    // abort after 5 issues
    clr_stats();
    launch(10, 1);
    n = 0;
    while (dut_issues < 5 && n < 50) begin step(); n++; end
    chk("f_five_issues", dut_issues, 5);
    s_axis_temp_valid = 1'b0; s_axis_power_valid = 1'b0; s_core_result_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("f_abort_busy", busy, 1'b0);
    chk("f_abort_iter", iter_count, 16'd0);
    repeat (3) step();
    chk("f_abort_no_done", dut_dones, 0);

    // reset in the middle of a run
    launch(10, 2);
    repeat (6) step();
    axi_resetn = 1'b0;
    repeat (2) step();
    chk("g_rst_busy", busy, 1'b0);
    chk("g_rst_lock", cfg_lock, 1'b0);
    chk("g_rst_iter", iter_count, 16'd0);
    chk("g_rst_core_valid", m_core_valid, 1'b0);
    chk("g_rst_power_ready", s_axis_power_ready, 1'b0);
    axi_resetn = 1'b1;
    step();

    // random runs
    for (int r = 0; r < 6; r++) begin
      int c, it;
      c  = $urandom_range(1, 12);
      it = $urandom_range(1, 3);
      set_probs($urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100),
                $urandom_range(40, 100), $urandom_range(40, 100));
      clr_stats();
      launch(c, it);
      run_until_idle("rnd", 3000);
      chk("rnd_dones", dut_dones, 1);
      chk("rnd_tlasts", dut_tlasts, it);
      chk("rnd_iter", iter_count, it);
      chk("rnd_results", dut_accepts, c * it);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
